op_key_encoder: RTL and testbench

- Front-end command source for the ALU operation decoder.
- Turns three raw pushbuttons (add, sub, mult) into a 4-bit opKey code:
  - 4'b1100 sum
  - 4'b1101 sub
  - 4'b1110 mult
- Issues each code once per press over a valid/ready handshake, then holds the last code on opKey so the downstream decoder always sees a legal operation.
- Includes input synchronisation, debouncing, press-edge detection and multi-press rejection.

---
 rtl/op_key_encoder.sv | 180 ++++++++++++++++++
 tb/tb_op_key_encoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/op_key_encoder.sv
// Pushbutton front end for the ALU operation decoder: synchronises, debounces and
// edge-detects three buttons and issues one opKey per press over valid/ready.
module op_key_encoder #(
  parameter int DEBOUNCE = 4,
  parameter int DB_W     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnAdd,
  input  logic       btnSub,
  input  logic       btnMul,
  output logic [3:0] opKey,
  output logic       opValid,
  input  logic       opReady,
  output logic       busy,
  output logic       errMulti
);

  localparam logic [3:0]      KEY_SUM = 4'b1100;
  localparam logic [3:0]      KEY_SUB = 4'b1101;
  localparam logic [3:0]      KEY_MUL = 4'b1110;
  localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DEBOUNCE - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ISSUE        = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  logic [2:0] raw;
  logic [2:0] sync_s;

  assign raw = {btnMul, btnSub, btnAdd};

  // Two-flop synchroniser per button; bit order is {mul, sub, add}.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
      logic [1:0] sync_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_reg <= 2'b00;
        end else begin
          sync_reg <= {sync_reg[0], raw[gi]};
        end
      end

      assign sync_s[gi] = sync_reg[1];
    end
  endgenerate

  logic [2:0]      cand_reg;
  logic [2:0]      stable_reg;
  logic [2:0]      stable_prev_reg;
  logic [DB_W-1:0] cnt_reg;

  // Whole-vector debounce: any change restarts the count, so a simultaneous
  // two-button press is seen as one multi-bit event rather than two presses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_reg        <= 3'b000;
      stable_reg      <= 3'b000;
      stable_prev_reg <= 3'b000;
      cnt_reg         <= '0;
    end else begin
      stable_prev_reg <= stable_reg;
      if (sync_s != cand_reg) begin
        cand_reg <= sync_s;
        cnt_reg  <= '0;
      end else if (cnt_reg == CNT_MAX) begin
        stable_reg <= cand_reg;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  logic [2:0] press;
  logic       press_multi;
  logic       press_single;
  logic [3:0] press_code;

  assign press        = stable_reg & ~stable_prev_reg;
  assign press_multi  = (press[0] & press[1]) | (press[0] & press[2]) | (press[1] & press[2]);
  assign press_single = (|press) & ~press_multi;

  always_comb begin
    press_code = KEY_SUM;
    case (press)
      3'b001:  press_code = KEY_SUM;
      3'b010:  press_code = KEY_SUB;
      3'b100:  press_code = KEY_MUL;
      default: press_code = KEY_SUM;
    endcase
  end

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] opkey_reg;
  logic [3:0] opkey_next;
  logic       opvalid_reg;
  logic       opvalid_next;
  logic       errmulti_reg;
  logic       errmulti_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (press_single) begin
          state_next = ISSUE;
        end else if (press_multi) begin
          state_next = WAIT_RELEASE;
        end
      end
      ISSUE: begin
        if (opvalid_reg && opReady) begin
          state_next = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (stable_reg == 3'b000) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Presses seen outside IDLE are deliberately dropped: one issue per press-release.
  always_comb begin
    opkey_next    = opkey_reg;
    opvalid_next  = opvalid_reg;
    errmulti_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (press_single) begin
          opkey_next   = press_code;
          opvalid_next = 1'b1;
        end else if (press_multi) begin
          errmulti_next = 1'b1;
        end
      end
      ISSUE: begin
        if (opvalid_reg && opReady) begin
          opvalid_next = 1'b0;
        end
      end
      default: begin
        opvalid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      opkey_reg    <= KEY_SUM;
      opvalid_reg  <= 1'b0;
      errmulti_reg <= 1'b0;
    end else begin
      opkey_reg    <= opkey_next;
      opvalid_reg  <= opvalid_next;
      errmulti_reg <= errmulti_next;
    end
  end

  assign opKey    = opkey_reg;
  assign opValid  = opvalid_reg;
  assign errMulti = errmulti_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_op_key_encoder.sv
// Scoreboard bench for op_key_encoder: expected issues/errors are queued when a
// press is driven and retired when the DUT transfers an opKey or pulses errMulti.
module tb_op_key_encoder;

  logic       clk;
  logic       rst;
  logic       btnAdd;
  logic       btnSub;
  logic       btnMul;
  logic [3:0] opKey;
  logic       opValid;
  logic       opReady;
  logic       busy;
  logic       errMulti;

  op_key_encoder #(.DEBOUNCE(4), .DB_W(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .btnAdd   (btnAdd),
    .btnSub   (btnSub),
    .btnMul   (btnMul),
    .opKey    (opKey),
    .opValid  (opValid),
    .opReady  (opReady),
    .busy     (busy),
    .errMulti (errMulti)
  );

  typedef struct {
    bit         is_err;
    logic [3:0] key;
  } ev_t;

  ev_t sb[$];
  int  nvec = 0;
  int  nerr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_err, input logic [3:0] key);
    ev_t e;
    e.is_err = is_err;
    e.key    = key;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      step();
      if (!busy) break;
    end
    check({"idle_", tag}, busy, 0);
  endtask

  // Retire scoreboard entries on each observed transfer or error pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (opValid && opReady) begin
        ev_t e;
        $display("xfer opKey=%b", opKey);
        check("xfer_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("xfer_kind", 0, e.is_err);
          check("xfer_key", opKey, e.key);
        end
      end
      if (errMulti) begin
        ev_t e;
        $display("errMulti pulse opKey=%b", opKey);
        check("err_expected", sb.size() > 0, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check("err_kind", 1, e.is_err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int         k;
  int         npulse;
  logic [9:0] bounce;

  initial begin
    rst = 1'b1; btnAdd = 1'b0; btnSub = 1'b0; btnMul = 1'b0; opReady = 1'b0;
    repeat (3) step();
    check("rst_key", opKey, 4'b1100);
    check("rst_valid", opValid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", errMulti, 0);
    rst = 1'b0;
    repeat (2) step();

    // Clean add, ready tied high: one-cycle opValid after edge 7.
    opReady = 1'b1;
    push(0, 4'b1100);
    for (int e = 0; e < 30; e++) begin
      btnAdd = (e < 20);
      step();
      check("add_valid", opValid, (e == 7));
      check("add_busy", busy, (e >= 7 && e < 27));
      check("add_key", opKey, 4'b1100);
    end
    $display("add press done");

    // Sub with back-pressure.
    opReady = 1'b0;
    btnSub  = 1'b1;
    push(0, 4'b1101);
    for (k = 0; k < 20; k++) begin
      step();
      if (opValid) break;
    end
    check("sub_latency", k, 7);
    repeat (5) begin
      step();
      check("sub_hold_valid", opValid, 1);
      check("sub_hold_key", opKey, 4'b1101);
    end
    opReady = 1'b1;
    step();
    check("sub_drop_valid", opValid, 0);
    check("sub_keep_key", opKey, 4'b1101);
    btnSub = 1'b0;
    wait_idle("sub", 30);
    $display("sub press done");

    // Bouncy mult: 1-2 cycle pulses, then steady.
    bounce = 10'b1011010010;
    for (int i = 0; i < 10; i++) begin
      btnMul = bounce[i];
      step();
      check("mul_bounce_valid", opValid, 0);
    end
    btnMul = 1'b1;
    push(0, 4'b1110);
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (opValid) npulse++;
    end
    check("mul_pulses", npulse, 1);
    check("mul_key", opKey, 4'b1110);
    btnMul = 1'b0;
    wait_idle("mul", 30);
    $display("mult press done");

    // Multi-press from a fresh reset.
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    check("multi_rst_key", opKey, 4'b1100);
    btnAdd = 1'b1;
    btnMul = 1'b1;
    push(1, 4'b0000);
    for (int e = 0; e < 12; e++) begin
      step();
      check("multi_err", errMulti, (e == 7));
      check("multi_valid", opValid, 0);
      check("multi_key", opKey, 4'b1100);
    end
    btnAdd = 1'b0;
    btnMul = 1'b0;
    wait_idle("multi", 30);
    btnSub = 1'b1;
    push(0, 4'b1101);
    npulse = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (opValid) npulse++;
    end
    check("multi_sub_pulses", npulse, 1);
    check("multi_sub_key", opKey, 4'b1101);
    btnSub = 1'b0;
    wait_idle("multi_sub", 30);
    $display("multi press done");

    // Reset while an issue is pending.
    opReady = 1'b0;
    btnMul  = 1'b1;
    push(0, 4'b1110);
    for (k = 0; k < 20; k++) begin
      step();
      if (opValid) break;
    end
    check("rmid_latency", k, 7);
    repeat (2) step();
    rst = 1'b1;
    sb.delete();
    step();
    check("rmid_valid", opValid, 0);
    check("rmid_key", opKey, 4'b1100);
    check("rmid_busy", busy, 0);
    check("rmid_err", errMulti, 0);
    push(0, 4'b1110);
    rst     = 1'b0;
    opReady = 1'b1;
    for (int e = 0; e < 12; e++) begin
      step();
      check("rmid_reissue", opValid, (e == 7));
    end
    check("rmid_reissue_key", opKey, 4'b1110);
    btnMul = 1'b0;
    wait_idle("rmid", 30);
    $display("reset mid-issue done");

    repeat (2) step();
    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
